alu_seq_hs: RTL and testbench
=============================

// Module: alu_seq_hs
// PURPOSE
//  Parametrised, registered ALU with valid/ready handshakes on input and result.
//  Extends the datapath ALU op set (ADD/OR/SLL/SUB) with AND, XOR, SRL, SRA, SLT and a
//  multi-cycle shift-add MUL. Produces registered V/Z/N/C status flags.
//  Sits between the register-file read stage and writeback, so the datapath can stall on MUL.
// PARAMETERS
//  WIDTH    32                  operand/result width in bits; must be >= 4
//  SHAMT_W  $clog2(WIDTH)       derived; shift amount = b[SHAMT_W-1:0]
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      operands and sel are valid
//  in_ready   out  1      block can accept an op
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sel        in   4      op: 0 ADD, 1 OR, 2 SLL, 3 SUB, 4 AND, 5 XOR, 6 SRL, 7 SRA, 8 SLT, 9 MUL
//  out_valid  out  1      out/stat/err are valid
//  out_ready  in   1      consumer takes the result
//  out        out  WIDTH  registered result
//  stat       out  4      {V,Z,N,C}, registered with out
//  err        out  1      1 = sel was 10..15
// BEHAVIOUR
//  - Reset: rst_n sampled low at a clk edge gives:
//    - state = IDLE, in_ready = 1, out_valid = 0, out = 0, stat = 0, err = 0, MUL counter = 0.
//    - Reset mid-MUL abandons the op. No result is ever presented for it.
//  - FSM states:
//    - IDLE: in_ready = 1. On in_valid & in_ready, a/b/sel are latched.
//      - Single-cycle op or illegal sel: go to DONE.
//      - MUL: go to BUSY.
//    - BUSY: in_ready = 0. Does one shift-add step per cycle; counter runs 0..WIDTH-1.
//      After step WIDTH-1, go to DONE.
//    - DONE: out_valid = 1, in_ready = 0. out/stat/err are held stable.
//      On out_ready, go to IDLE. in_ready rises the next cycle; there is no same-cycle re-accept.
//  - Latency, accept edge to out_valid high:
//    - single-cycle ops: 1 cycle.
//    - MUL: WIDTH+1 cycles.
//  - in_valid is ignored outside IDLE. Operands are captured at accept, so later input changes have no effect.
//  - Arithmetic (all modulo 2^WIDTH):
//    - SUB = a + ~b + 1.
//    - SLT = signed(a) < signed(b) ? 1 : 0, zero-extended.
//    - MUL = low WIDTH bits of unsigned a*b.
//    - Shift amount uses only b[SHAMT_W-1:0], so WIDTH=32 with b=35 shifts by 3.
//    - SRA replicates a[WIDTH-1].
//  - Flags (computed on the final result):
//    - Z = (out == 0).
//    - N = out[WIDTH-1].
//    - ADD: C = carry out of bit WIDTH-1; V = a,b same sign and out sign differs.
//    - SUB: C = 1 when there is no borrow (a >= b unsigned); V = a,b signs differ and out sign != a sign.
//    - All other ops: V = C = 0.
//  - Illegal sel (10..15): out = 0, stat = 4'b0100, err = 1. Takes the single-cycle path.
//  - err is 0 for all legal ops.
// TESTING (WIDTH=32)
//  1. ADD a=0x7FFFFFFF b=1 -> out=0x80000000, stat=4'b1010, out_valid one cycle after accept.
//  2. SUB 5-5 -> out=0, stat=4'b0101.
//     SUB 3-5 -> out=0xFFFFFFFE, stat=4'b0010.
//  3. MUL 0x0000FFFF*0x00010001 -> out=0xFFFFFFFF, stat=4'b0010.
//     out_valid exactly 33 cycles after accept; in_ready=0 throughout.
//  4. Backpressure: result in DONE, out_ready=0 for 5 cycles, in_valid=1 with new operands
//     -> out/stat stable, nothing accepted. out_ready=1 -> IDLE, and in_ready=1 the next cycle.
//  5. rst_n=0 for 1 cycle at MUL step 10 -> IDLE, out_valid=0, in_ready=1.
//     A following ADD 2+3 returns 5 with no trace of the MUL.
//  6. SRA a=0x80000000 b=35 -> out=0xF0000000, stat=4'b0010.
//     sel=4'hF -> out=0, stat=4'b0100, err=1.

Source files
------------

// File: rtl/alu_seq_hs_if.sv
// Handshake bundle for alu_seq_hs: operand side (in_*, a, b, sel)
// and result side (out_*, out, stat, err). master drives ops, slave is the ALU.
`timescale 1ns/1ps
interface alu_seq_hs_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [3:0]       stat;
  logic             err;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, out, stat, err
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, out, stat, err
  );
endinterface

// File: rtl/alu_seq_hs.sv
// Registered ALU with valid/ready handshakes and a shift-add MUL.
// Ports: clk, rst_n (sync, active low), bus (alu_seq_hs_if.slave).
`timescale 1ns/1ps
module alu_seq_hs #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_seq_hs_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);
  localparam int M = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [3:0]         stat_q, stat_d;
  logic               err_q, err_d;

  logic op_add, op_or, op_sll, op_sub, op_and;
  logic op_xor, op_srl, op_sra, op_slt, op_mul;

  logic [WIDTH:0]     sum_w, diff_w;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v, alu_c, alu_err;
  logic [WIDTH-1:0]   acc_n;

  assign op_add = bus.sel == 4'd0;
  assign op_or  = bus.sel == 4'd1;
  assign op_sll = bus.sel == 4'd2;
  assign op_sub = bus.sel == 4'd3;
  assign op_and = bus.sel == 4'd4;
  assign op_xor = bus.sel == 4'd5;
  assign op_srl = bus.sel == 4'd6;
  assign op_sra = bus.sel == 4'd7;
  assign op_slt = bus.sel == 4'd8;
  assign op_mul = bus.sel == 4'd9;

  assign shamt = bus.b[SHAMT_W-1:0];

  // SUB as a + ~b + 1: the carry out is the "no borrow" flag
  always_comb begin
    sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
    diff_w = {1'b0, bus.a} + {1'b0, ~bus.b}
           + {{WIDTH{1'b0}}, 1'b1};
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    unique case (1'b1)
      op_add: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (bus.a[M] == bus.b[M])
                & (alu_res[M] != bus.a[M]);
      end
      op_sub: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (bus.a[M] != bus.b[M])
                & (alu_res[M] != bus.a[M]);
      end
      op_or:  alu_res = bus.a | bus.b;
      op_and: alu_res = bus.a & bus.b;
      op_xor: alu_res = bus.a ^ bus.b;
      op_sll: alu_res = bus.a << shamt;
      op_srl: alu_res = bus.a >> shamt;
      op_sra: alu_res = $unsigned($signed(bus.a) >>> shamt);
      op_slt: alu_res = {{(WIDTH-1){1'b0}},
                         $signed(bus.a) < $signed(bus.b)};
      op_mul: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  assign acc_n = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    stat_d   = stat_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (op_mul) begin
            acc_d    = '0;
            mcand_d  = bus.a;
            mplier_d = bus.b;
            cnt_d    = '0;
            state_d  = BUSY;
          end else begin
            out_d   = alu_res;
            stat_d  = {alu_v, alu_res == '0,
                       alu_res[M], alu_c};
            err_d   = alu_err;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        acc_d    = acc_n;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          out_d   = acc_n;
          stat_d  = {1'b0, acc_n == '0, acc_n[M], 1'b0};
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      stat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      stat_q   <= stat_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out       = out_q;
  assign bus.stat      = stat_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_seq_hs.sv
// Self-checking bench for alu_seq_hs (WIDTH=32): directed cases
// plus randomized ops against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq_hs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_seq_hs_if #(.WIDTH(32)) bus ();

  alu_seq_hs #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] s,
                                input logic [31:0] x,
                                input logic [31:0] y,
                                output logic [31:0] r,
                                output logic [3:0] st,
                                output logic e);
    longint sx, sy, sr;
    logic [63:0] w;
    int sh;
    logic v, c;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y % 32);
    v = 1'b0;
    c = 1'b0;
    e = 1'b0;
    r = '0;
    case (s)
      4'd0: begin
        w = {32'b0, x} + {32'b0, y};
        r = w[31:0];
        c = w[32];
        sr = sx + sy;
        v = sr > 64'sd2147483647 || sr < -64'sd2147483648;
      end
      4'd3: begin
        r = x - y;
        c = x >= y;
        sr = sx - sy;
        v = sr > 64'sd2147483647 || sr < -64'sd2147483648;
      end
      4'd1: r = x | y;
      4'd2: r = x << sh;
      4'd4: r = x & y;
      4'd5: r = x ^ y;
      4'd6: r = x >> sh;
      4'd7: begin
        sr = sx >>> sh;
        r = sr[31:0];
      end
      4'd8: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd9: begin
        w = {32'b0, x} * {32'b0, y};
        r = w[31:0];
      end
      default: e = 1'b1;
    endcase
    st = {v, r == 32'd0, r[31], c};
  endfunction

  // issue one op; returns latency (accept edge counts as 1)
  task automatic do_op(input logic [3:0] s,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       output int lat,
                       output logic busy_ok);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = x;
    bus.b = y;
    bus.sel = s;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.sel = 4'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 100) chk("result_timeout", 64'd0, 64'd1);
  endtask

  task automatic take(input string tag,
                      input logic [31:0] er,
                      input logic [3:0] es,
                      input logic ee);
    chk({tag, "_out"}, 64'(bus.out), 64'(er));
    chk({tag, "_stat"}, 64'(bus.stat), 64'(es));
    chk({tag, "_err"}, 64'(bus.err), 64'(ee));
    @(negedge clk);
    chk({tag, "_noacc"}, 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_vld"}, 64'(bus.out_valid), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    logic bok, stable, seen;
    logic [31:0] r, hold_o, x, y;
    logic [3:0] st, hold_s, s;
    logic e;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rdy", 64'(bus.in_ready), 64'd1);
    chk("rst_vld", 64'(bus.out_valid), 64'd0);
    chk("rst_out", 64'(bus.out), 64'd0);
    chk("rst_stat", 64'(bus.stat), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);

    do_op(4'd0, 32'h7FFF_FFFF, 32'd1, lat, bok);
    chk("add_lat", 64'(lat), 64'd1);
    take("add_ovf", 32'h8000_0000, 4'b1010, 1'b0);

    do_op(4'd3, 32'd5, 32'd5, lat, bok);
    take("sub_eq", 32'd0, 4'b0101, 1'b0);
    do_op(4'd3, 32'd3, 32'd5, lat, bok);
    take("sub_neg", 32'hFFFF_FFFE, 4'b0010, 1'b0);

    do_op(4'd9, 32'h0000_FFFF, 32'h0001_0001, lat, bok);
    chk("mul_lat", 64'(lat), 64'd33);
    chk("mul_busy", 64'(bok), 64'd1);
    take("mul", 32'hFFFF_FFFF, 4'b0010, 1'b0);

    do_op(4'd7, 32'h8000_0000, 32'd35, lat, bok);
    take("sra", 32'hF000_0000, 4'b0010, 1'b0);
    do_op(4'hF, 32'h1234, 32'h5678, lat, bok);
    chk("ill_lat", 64'(lat), 64'd1);
    take("ill", 32'd0, 4'b0100, 1'b1);

    // backpressure: result held while new op is offered
    do_op(4'd5, 32'hF0F0_1234, 32'h0FF0_4321, lat, bok);
    hold_o = bus.out;
    hold_s = bus.stat;
    stable = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sel = 4'd0;
    bus.a = 32'd100;
    bus.b = 32'd200;
    repeat (5) begin
      @(negedge clk);
      if (bus.out !== hold_o || bus.stat !== hold_s ||
          !bus.out_valid || bus.in_ready)
        stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    bus.in_valid = 1'b0;
    take("bp", 32'hFF00_5115, 4'b0010, 1'b0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("bp_none", 64'(seen), 64'd0);

    // reset in the middle of a MUL
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sel = 4'd9;
    bus.a = 32'd7;
    bus.b = 32'd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_vld", 64'(bus.out_valid), 64'd0);
    chk("mrst_rdy", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mrst_none", 64'(seen), 64'd0);
    do_op(4'd0, 32'd2, 32'd3, lat, bok);
    take("mrst_add", 32'd5, 4'b0000, 1'b0);

    // randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      s = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                      : 4'($urandom_range(0, 9));
      x = pick();
      y = pick();
      model(s, x, y, r, st, e);
      do_op(s, x, y, lat, bok);
      chk("rnd_lat", 64'(lat), (s == 4'd9) ? 64'd33 : 64'd1);
      take($sformatf("rnd%0d_s%0d", i, s), r, st, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
